mc_controller: RTL

Multicycle control unit for the MIPS core. It sequences a single shared datapath (one memory, one ALU, the IR/A/B/ALUOut registers) through fetch, decode, execute, memory and writeback steps for each instruction. It generates the per-step mux selects and write enables, and it stalls on a memory-ready handshake. It replaces the single-cycle control path when the core is built in multicycle form.

---
 rtl/mips_ctrl_pkg.sv | 74 +++++++
 rtl/aludec.sv | 20 ++
 rtl/mc_maindec.sv | 123 ++++++++++++
 rtl/mc_controller.sv | 74 +++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path: FSM states,
// opcode and funct values, aluop codes and datapath mux encodings.
package mips_ctrl_pkg;

    // One state per datapath step; 4-bit encoding leaves room for growth.
    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_RTYPEEX = 4'd7,
        S_RTYPEWB = 4'd8,
        S_BEQEX   = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JEX     = 4'd12
    } state_t;

    // Opcodes recognised by the decoder (instr[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes (instr[5:0]).
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // Internal ALU intent handed from the main decoder to aludec.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU operation codes seen by the datapath ALU.
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALU B operand select.
    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // Next-PC select.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Map an R-type funct field to an ALU operation; unknown functs fall back to AND
    function automatic logic [2:0] alu_for_funct(input logic [5:0] funct);
        logic [2:0] ctl;
        case (funct)
            FN_ADD:  ctl = ALU_ADD;
            FN_SUB:  ctl = ALU_SUB;
            FN_AND:  ctl = ALU_AND;
            FN_OR:   ctl = ALU_OR;
            FN_SLT:  ctl = ALU_SLT;
            default: ctl = ALU_AND;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/aludec.sv
// ALU decoder: turns the main decoder's aluop intent plus the funct field
// into the 3-bit operation code driven to the ALU.
module aludec
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    input  logic [1:0] aluop,
    output logic [2:0] alucontrol
);

    // Fixed add/subtract for address and branch math, otherwise follow funct
    always_comb begin
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            default:   alucontrol = alu_for_funct(funct);
        endcase
    end

endmodule

// File: rtl/mc_maindec.sv
// Combinational main decoder for the multicycle controller: computes the
// next state and the per-step datapath controls from the current state,
// the opcode and the memory-ready handshake.
module mc_maindec
    import mips_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output state_t     next_state,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       pcwrite,
    output logic       branch,
    output logic       illegal
);

    // Every control defaults low; each step raises only what it needs
    always_comb begin
        next_state = state;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_B;
        pcsrc      = PCSRC_ALU;
        aluop      = ALUOP_ADD;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        illegal    = 1'b0;

        case (state)
            S_IDLE: begin
                next_state = S_FETCH;
            end
            S_FETCH: begin
                alusrcb    = SRCB_FOUR;
                irwrite    = mem_ready;
                pcwrite    = mem_ready;
                next_state = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrcb = SRCB_IMMSH;
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_RTYPEEX;
                    OP_BEQ:       next_state = S_BEQEX;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JEX;
                    default: begin
                        next_state = S_FETCH;
                        illegal    = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = SRCB_IMM;
                next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord       = 1'b1;
                next_state = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite   = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                memwrite   = 1'b1;
                next_state = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_RTYPEEX: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_FUNCT;
                next_state = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regdst     = 1'b1;
                regwrite   = 1'b1;
                next_state = S_FETCH;
            end
            S_BEQEX: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_SUB;
                pcsrc      = PCSRC_ALUOUT;
                branch     = 1'b1;
                next_state = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = SRCB_IMM;
                next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite   = 1'b1;
                next_state = S_FETCH;
            end
            S_JEX: begin
                pcsrc      = PCSRC_JUMP;
                pcwrite    = 1'b1;
                next_state = S_FETCH;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: holds the step register, decodes the
// per-step datapath controls and combines PC write and branch into pcen.
module mc_controller
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic [2:0] alucontrol,
    output logic       illegal
);

    state_t     state_q;
    state_t     state_d;
    logic [1:0] aluop;
    logic       pcwrite;
    logic       branch;
    logic [2:0] alu_raw;

    mc_maindec u_maindec (
        .state      (state_q),
        .op         (op),
        .mem_ready  (mem_ready),
        .next_state (state_d),
        .iord       (iord),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .aluop      (aluop),
        .pcwrite    (pcwrite),
        .branch     (branch),
        .illegal    (illegal)
    );

    aludec u_aludec (
        .funct      (funct),
        .aluop      (aluop),
        .alucontrol (alu_raw)
    );

    // Step register; reset drops straight to IDLE so every write enable dies at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // PC loads on an unconditional write or a taken branch
    assign pcen = pcwrite | (branch & zero);

    // IDLE keeps the whole output bundle at zero, including the ALU code
    assign alucontrol = (state_q == S_IDLE) ? 3'b000 : alu_raw;

endmodule
